// File: rtl/down_counter_timer.sv
// Loadable down-counter/timer with one-shot or auto-reload, pause/resume and terminal-count pulse.
// Define DCT_PRESCALE_EN to add the prescale port (tick once every prescale+1 cycles).
module down_counter_timer #(
  parameter int WIDTH      = 4,
  parameter int PRESCALE_W = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  load,
  input  logic [WIDTH-1:0]      load_val,
  input  logic                  start,
  input  logic                  stop,
  input  logic                  auto_reload,
`ifdef DCT_PRESCALE_EN
  input  logic [PRESCALE_W-1:0] prescale,
`endif
  output logic [WIDTH-1:0]      q,
  output logic                  busy,
  output logic                  tc
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t                state;
  logic [WIDTH-1:0]      reload;
  logic [PRESCALE_W-1:0] pcnt;
  logic [PRESCALE_W-1:0] pdiv;
  logic [PRESCALE_W-1:0] prescale_in;
  logic                  tick;

`ifdef DCT_PRESCALE_EN
  assign prescale_in = prescale;
`else
  assign prescale_in = '0;
`endif

  // pdiv holds the divider captured at the last prescaler clear/wrap
  assign tick = (pcnt == pdiv);

  function automatic logic [WIDTH-1:0] dec(input logic [WIDTH-1:0] v);
    return v - WIDTH'(1);
  endfunction

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      q      <= '0;
      reload <= '0;
      busy   <= 1'b0;
      tc     <= 1'b0;
      state  <= IDLE;
      pcnt   <= '0;
      pdiv   <= '0;
    end else begin
      tc <= 1'b0;
      if (load) begin
        q      <= load_val;
        reload <= load_val;
        state  <= IDLE;
        busy   <= 1'b0;
        pcnt   <= '0;
        pdiv   <= prescale_in;
      end else if (stop) begin
        if (state == RUN) begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        pcnt <= '0;
        pdiv <= prescale_in;
      end else if (start && state != RUN) begin
        pcnt <= '0;
        pdiv <= prescale_in;
        if (state == IDLE && q != '0) begin
          state <= RUN;
          busy  <= 1'b1;
        end else if (state == DONE && reload != '0) begin
          q     <= reload;
          state <= RUN;
          busy  <= 1'b1;
        end
      end else if (state == RUN) begin
        if (tick) begin
          pcnt <= '0;
          pdiv <= prescale_in;
          if (q > WIDTH'(1)) begin
            q <= dec(q);
          end else if (auto_reload) begin
            q  <= reload;
            tc <= 1'b1;
          end else begin
            q     <= '0;
            tc    <= 1'b1;
            state <= DONE;
            busy  <= 1'b0;
          end
        end else begin
          pcnt <= pcnt + PRESCALE_W'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_down_counter_timer.sv
// Scoreboard bench for down_counter_timer: a cycle model pushes expected outputs, the DUT is popped against them.
// Honours DCT_PRESCALE_EN when the bundle is built with it.
module tb_down_counter_timer;

  localparam int WIDTH = 4;
  localparam int PW    = 4;
  localparam int S_IDLE = 0, S_RUN = 1, S_DONE = 2;

  logic             clk;
  logic             reset;
  logic             load;
  logic [WIDTH-1:0] load_val;
  logic             start;
  logic             stop;
  logic             auto_reload;
  logic [PW-1:0]    prescale;
  logic [WIDTH-1:0] q;
  logic             busy;
  logic             tc;

  down_counter_timer #(.WIDTH(WIDTH), .PRESCALE_W(PW)) dut (
    .clk         (clk),
    .reset       (reset),
    .load        (load),
    .load_val    (load_val),
    .start       (start),
    .stop        (stop),
    .auto_reload (auto_reload),
`ifdef DCT_PRESCALE_EN
    .prescale    (prescale),
`endif
    .q           (q),
    .busy        (busy),
    .tc          (tc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string tag;
    int    q;
    int    busy;
    int    tc;
  } exp_t;

  exp_t sb[$];
  int   n_chk = 0;
  int   n_err = 0;

  // reference model state
  int m_q, m_rl, m_st, m_busy, m_tc, m_pc, m_pd;
  int ps_val = 0;

  task automatic check(input string tag, input int act, input int exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", tag, act, exp);
    end
  endtask

  task automatic model_reset();
    m_q = 0; m_rl = 0; m_st = S_IDLE; m_busy = 0; m_tc = 0; m_pc = 0; m_pd = 0;
  endtask

  task automatic model_step(input int ld, input int lv, input int st, input int sp, input int ar);
    m_tc = 0;
    if (ld != 0) begin
      m_q = lv; m_rl = lv; m_st = S_IDLE; m_pc = 0; m_pd = ps_val;
    end else if (sp != 0) begin
      if (m_st == S_RUN) m_st = S_IDLE;
      m_pc = 0; m_pd = ps_val;
    end else if (st != 0 && m_st != S_RUN) begin
      m_pc = 0; m_pd = ps_val;
      if (m_st == S_IDLE && m_q != 0) m_st = S_RUN;
      else if (m_st == S_DONE && m_rl != 0) begin
        m_q = m_rl; m_st = S_RUN;
      end
    end else if (m_st == S_RUN) begin
      if (m_pc == m_pd) begin
        m_pc = 0; m_pd = ps_val;
        if (m_q >= 2) m_q = m_q - 1;
        else begin
          m_tc = 1;
          if (ar != 0) m_q = m_rl;
          else begin
            m_q = 0; m_st = S_DONE;
          end
        end
      end else begin
        m_pc = m_pc + 1;
      end
    end
    m_busy = (m_st == S_RUN) ? 1 : 0;
  endtask

  // one clock: drive, predict, wait the edge, then compare 1ns later
  task automatic cyc(input string tag, input int ld, input int lv, input int st, input int sp, input int ar);
    exp_t e;
    load        = (ld != 0);
    load_val    = WIDTH'(lv);
    start       = (st != 0);
    stop        = (sp != 0);
    auto_reload = (ar != 0);
    prescale    = PW'(ps_val);
    model_step(ld, lv, st, sp, ar);
    sb.push_back('{tag, m_q, m_busy, m_tc});
    @(posedge clk);
    #1;
    e = sb.pop_front();
    check({e.tag, ".q"},    int'(q),    e.q);
    check({e.tag, ".busy"}, int'(busy), e.busy);
    check({e.tag, ".tc"},   int'(tc),   e.tc);
    load  = 1'b0;
    start = 1'b0;
    stop  = 1'b0;
  endtask

  task automatic idle(input string tag, input int n, input int ar);
    for (int i = 0; i < n; i++) cyc(tag, 0, 0, 0, 0, ar);
  endtask

  initial begin
    reset = 1'b0; load = 1'b0; load_val = '0; start = 1'b0; stop = 1'b0;
    auto_reload = 1'b0; prescale = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check("rst.q", int'(q), 0);
    check("rst.busy", int'(busy), 0);
    check("rst.tc", int'(tc), 0);
    reset = 1'b1;

    // one-shot from 3
    cyc("os_load", 1, 3, 0, 0, 0);
    cyc("os_start", 0, 0, 1, 0, 0);
    idle("os_run", 5, 0);
    // restart from DONE uses reload
    cyc("done_start", 0, 0, 1, 0, 0);
    idle("done_run", 4, 0);

    // auto-reload from 2
    cyc("ar_load", 1, 2, 0, 0, 1);
    cyc("ar_start", 0, 0, 1, 0, 1);
    idle("ar_run", 6, 1);
    // auto_reload dropped: expires at next terminal count
    idle("ar_drop", 3, 0);

    // pause and resume
    cyc("pr_load", 1, 5, 0, 0, 0);
    cyc("pr_start", 0, 0, 1, 0, 0);
    idle("pr_run", 2, 0);
    cyc("pr_stop", 0, 0, 0, 1, 0);
    idle("pr_hold", 2, 0);
    cyc("pr_both", 0, 0, 1, 1, 0);
    cyc("pr_resume", 0, 0, 1, 0, 0);
    idle("pr_run2", 4, 0);

    // load beats start+stop just before terminal count
    cyc("lp_load", 1, 2, 0, 0, 0);
    cyc("lp_start", 0, 0, 1, 0, 0);
    cyc("lp_run", 0, 0, 0, 0, 0);
    cyc("lp_all", 1, 7, 1, 1, 0);
    idle("lp_idle", 2, 0);

    // start with q==0 ignored; stop in DONE ignored
    cyc("z_load", 1, 0, 0, 0, 0);
    cyc("z_start", 0, 0, 1, 0, 0);
    cyc("d_load", 1, 1, 0, 0, 0);
    cyc("d_start", 0, 0, 1, 0, 0);
    cyc("d_exp", 0, 0, 0, 0, 0);
    cyc("d_stop", 0, 0, 0, 1, 0);
    cyc("d_start2", 0, 0, 1, 0, 0);
    idle("d_run", 2, 0);

    // reload==1 with auto-reload: tc every tick
    cyc("r1_load", 1, 1, 0, 0, 1);
    cyc("r1_start", 0, 0, 1, 0, 1);
    idle("r1_run", 4, 1);

    // full-scale one-shot
    cyc("max_load", 1, 15, 0, 0, 0);
    cyc("max_start", 0, 0, 1, 0, 0);
    idle("max_run", 16, 0);

    // random traffic
    for (int i = 0; i < 300; i++) begin
      cyc("rnd", int'($urandom_range(0, 15) == 0), int'($urandom_range(0, 15)),
          int'($urandom_range(0, 3) == 0), int'($urandom_range(0, 7) == 0),
          int'($urandom_range(0, 1)));
    end

`ifdef DCT_PRESCALE_EN
    ps_val = 2;
    cyc("ps_load", 1, 2, 0, 0, 0);
    cyc("ps_start", 0, 0, 1, 0, 0);
    idle("ps_run", 8, 0);
    ps_val = 1;
    cyc("ps1_load", 1, 3, 0, 0, 1);
    cyc("ps1_start", 0, 0, 1, 0, 1);
    idle("ps1_run", 9, 1);
    ps_val = 0;
`endif

    // asynchronous reset between edges while running at q=5
    cyc("ar5_load", 1, 5, 0, 0, 0);
    cyc("ar5_start", 0, 0, 1, 0, 0);
    check("pre_rst.q", int'(q), 5);
    check("pre_rst.busy", int'(busy), 1);
    #3;
    reset = 1'b0;
    #1;
    check("async.q", int'(q), 0);
    check("async.busy", int'(busy), 0);
    check("async.tc", int'(tc), 0);
    @(posedge clk);
    #1;
    check("hold.q", int'(q), 0);
    check("hold.busy", int'(busy), 0);
    reset = 1'b1;
    model_reset();
    cyc("post_start", 0, 0, 1, 0, 0);
    cyc("post_load", 1, 4, 0, 0, 0);
    cyc("post_go", 0, 0, 1, 0, 0);
    idle("post_run", 5, 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
